dmem_bus_bridge: RTL
====================

Name: dmem_bus_bridge

Overview:
- Sits directly downstream of the core's memory stage: consumes the M-stage data-port outputs (ALUResultM, WriteDataM, MemWriteM, byteEnable) plus a new MemReadM strobe.
- Converts each access into a valid/ready request and response transaction on a variable-latency data bus.
- Returns load data on RD_data and holds the pipeline through MemStall, which the hazard unit ORs into its stall/flush logic alongside MulBusy.

Parameters:
- ADDR_W, 32: bus address width; the low ADDR_W bits of ALUResultM are forwarded.
- TIMEOUT_CYCLES, 255: response-wait limit in cycles; used only when DMEM_TIMEOUT_EN is defined; legal range 1..65535.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- MemReadM  in  1  load in M stage
- MemWriteM  in  1  store in M stage
- ALUResultM  in  32  byte address
- WriteDataM  in  32  store data, already lane-aligned by the core
- byteEnable  in  4  store byte lanes
- RD_data  out  32  load data to the core writeback path
- MemStall  out  1  hold F/D/E/M stages and bubble W
- mem_err  out  1  one-cycle pulse: bus error (or timeout) on the completing access
- bus_req_valid  out  1  request valid
- bus_req_ready  in  1  request accepted
- bus_req_addr  out  ADDR_W  request address
- bus_req_we  out  1  1 = write
- bus_req_be  out  4  write byte enables; 4'b1111 for reads
- bus_req_wdata  out  32  write data
- bus_rsp_valid  in  1  response valid
- bus_rsp_rdata  in  32  read data
- bus_rsp_err  in  1  response error

Behaviour:
- FSM states: IDLE, REQ, RSP, DONE. Reset state: IDLE.
- Reset (reset=0, async): state=IDLE. RD_data, MemStall, mem_err, bus_req_valid, bus_req_we, bus_req_be, bus_req_addr and bus_req_wdata are all 0.
- IDLE, access present (MemReadM|MemWriteM):
  - Latch addr, wdata, be and we=MemWriteM.
  - If MemReadM and MemWriteM are both 1, the access is a write.
  - Next state REQ.
  - MemStall=1 combinationally in this same cycle.
- IDLE, no access: MemStall=0 and the state stays IDLE.
- REQ:
  - bus_req_valid=1; address, data, we and be are held stable from the latched copies.
  - On bus_req_ready=1 the next state is RSP.
  - MemStall=1.
- RSP:
  - On bus_rsp_valid=1 the next state is DONE.
  - For reads, bus_rsp_rdata is captured into RD_data (0 if bus_rsp_err=1).
  - Error flag is latched from bus_rsp_err. MemStall=1.
- DONE:
  - MemStall=0 and mem_err=latched error; the pipeline advances at the end of this cycle.
  - Next state IDLE unconditionally. A new access is seen in IDLE on the following cycle.
- Minimum access latency with ready and rsp both 1 at first opportunity: 3 stall cycles, then the DONE cycle.
- A write never modifies RD_data. RD_data holds its value until the next read completes.
- bus_rsp_valid outside RSP is ignored; no same-cycle request accept plus response.
- bus_req_valid must not drop before ready, and request fields must not change while valid=1.
- Reset mid-transaction aborts to IDLE. A late bus response after reset is ignored.
- Exactly one outstanding transaction at a time; no pipelining of requests.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on RSP entry and increments each RSP cycle without bus_rsp_valid.
  - When it reaches TIMEOUT_CYCLES, the FSM goes to DONE with RD_data=0 (for reads) and mem_err=1.
  - A late response arriving after that is ignored.
- Not defined: no counter; RSP waits indefinitely for bus_rsp_valid.

Test Plan:
1. Load, addr 0x0000_0040, ready=1 immediately, rsp_valid next cycle with rdata 0xDEAD_BEEF:
   - MemStall=1 for 3 cycles, then 0.
   - RD_data=0xDEADBEEF in DONE.
   - bus_req_we=0, bus_req_be=4'hF.
2. Store, addr 0x100, wdata 0x1234_5678, be 4'b0011, ready delayed 4 cycles:
   - bus_req_valid held 5 cycles with stable fields.
   - bus_req_we=1, bus_req_be=4'b0011.
   - RD_data unchanged.
3. Load with bus_rsp_err=1:
   - RD_data=0.
   - mem_err=1 for exactly the DONE cycle, then 0.
4. Back-to-back load then store:
   - Second access starts in the IDLE cycle after DONE.
   - Exactly two bus requests are issued.
5. reset=0 asserted while in RSP:
   - All outputs go to 0 immediately.
   - A bus_rsp_valid arriving after reset release is ignored; state is IDLE.
6. With DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, no response:
   - DONE after 8 RSP cycles.
   - mem_err=1, RD_data=0.

Source files
------------

// File: rtl/dmem_bus_bridge.sv
// Bridges M-stage loads/stores onto a valid/ready data bus with one outstanding transaction.
// Latency: at least 3 MemStall cycles (IDLE, REQ, RSP), then a DONE cycle where the pipeline advances.
// Backpressure: request fields held until bus_req_ready; RSP waits for bus_rsp_valid (bounded when DMEM_TIMEOUT_EN).
module dmem_bus_bridge #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [31:0]       ALUResultM,
    input  logic [31:0]       WriteDataM,
    input  logic [3:0]        byteEnable,
    output logic [31:0]       RD_data,
    output logic              MemStall,
    output logic              mem_err,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [ADDR_W-1:0] bus_req_addr,
    output logic              bus_req_we,
    output logic [3:0]        bus_req_be,
    output logic [31:0]       bus_req_wdata,
    input  logic              bus_rsp_valid,
    input  logic [31:0]       bus_rsp_rdata,
    input  logic              bus_rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } stateT;

    stateT             stateQ;
    stateT             stateD;
    logic [ADDR_W-1:0] addrQ;
    logic [31:0]       wdataQ;
    logic [3:0]        beQ;
    logic              weQ;
    logic              errQ;
    logic              access;
    logic              timedOut;
    logic              rspDone;

    assign access  = MemReadM | MemWriteM;
    assign rspDone = (stateQ == RSP) && (bus_rsp_valid || timedOut);

`ifdef DMEM_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] toCntQ;

    // The count holds the number of silent RSP cycles already elapsed, so the
    // TIMEOUT_CYCLES-th silent cycle is the last one spent in RSP.
    assign timedOut = (stateQ == RSP) && !bus_rsp_valid && (toCntQ == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            toCntQ <= 16'd0;
        end else if (stateQ == REQ && bus_req_ready) begin
            toCntQ <= 16'd0;
        end else if (stateQ == RSP && !bus_rsp_valid) begin
            toCntQ <= toCntQ + 16'd1;
        end
    end
`else
    assign timedOut = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD   = stateQ;
        MemStall = 1'b0;
        case (stateQ)
            IDLE: begin
                // Stall in the cycle the access appears so the M-stage inputs stay put.
                if (access) begin
                    stateD   = REQ;
                    MemStall = reset;
                end
            end
            REQ: begin
                MemStall = 1'b1;
                if (bus_req_ready) begin
                    stateD = RSP;
                end
            end
            RSP: begin
                MemStall = 1'b1;
                if (bus_rsp_valid || timedOut) begin
                    stateD = DONE;
                end
            end
            DONE: begin
                stateD = IDLE;
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addrQ   <= '0;
            wdataQ  <= 32'd0;
            beQ     <= 4'd0;
            weQ     <= 1'b0;
            errQ    <= 1'b0;
            RD_data <= 32'd0;
        end else begin
            if (stateQ == IDLE && access) begin
                addrQ  <= ALUResultM[ADDR_W-1:0];
                wdataQ <= WriteDataM;
                beQ    <= MemWriteM ? byteEnable : 4'hF;
                weQ    <= MemWriteM;
            end
            if (rspDone) begin
                errQ <= bus_rsp_valid ? bus_rsp_err : 1'b1;
                // Stores leave the last load result untouched.
                if (!weQ) begin
                    RD_data <= (bus_rsp_valid && !bus_rsp_err) ? bus_rsp_rdata : 32'd0;
                end
            end
        end
    end

    assign bus_req_valid = (stateQ == REQ);
    assign bus_req_addr  = addrQ;
    assign bus_req_we    = weQ;
    assign bus_req_be    = beQ;
    assign bus_req_wdata = wdataQ;
    assign mem_err       = (stateQ == DONE) && errQ;

endmodule
